mul_valrdy_requester: RTL
=========================

Name: mul_valrdy_requester

Overview:
- Initiator side of the val/rdy multiply interface: buffers operand pairs from an upstream source and issues them one at a time to an n-bit iterative fixed-point multiplier (multiplier recv side).
- Collects each product from the multiplier send side and forwards it on a registered output stream.
- Keeps a running product sum, a completion count and a sticky timeout error for on-chip self-test.
- Sits between the chip-pin operand source and the multiplier instance, in the same clock domain.

Parameters:
- n, 6, operand/product width (matches multiplier n)
- DEPTH, 4, operand FIFO entries (power of two, >=2)
- TIMEOUT, 255, max cycles in WAIT before abort (fits 8-bit counter)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_val  in  1  upstream operand pair valid
- in_rdy  out  1  FIFO can accept (= !full)
- in_a  in  n  operand a
- in_b  in  n  operand b
- req_val  out  1  to multiplier recv_val
- req_rdy  in  1  from multiplier recv_rdy
- req_a  out  n  to multiplier a (FIFO head)
- req_b  out  n  to multiplier b (FIFO head)
- rsp_val  in  1  from multiplier send_val
- rsp_rdy  out  1  to multiplier send_rdy
- rsp_c  in  n  from multiplier c
- out_val  out  1  product available
- out_rdy  in  1  downstream accepts product
- out_c  out  n  registered product
- sum  out  n+4  wrapping sum of delivered products
- done_count  out  8  wrapping count of delivered products
- err  out  1  sticky timeout flag
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset values: in_rdy=1, req_val=0, rsp_rdy=0, out_val=0, out_c=0, req_a/req_b=0, sum=0, done_count=0, err=0, busy=0; FIFO empty, state IDLE, timeout counter 0.
- FIFO: push on in_val&&in_rdy; pop only on req handshake. in_rdy = !full, no bypass when full. Simultaneous push and pop with FIFO full is not possible (in_rdy=0). Simultaneous push and pop otherwise keeps the count unchanged. Pointers wrap mod DEPTH. req_a/req_b always show the FIFO head, or 0 when empty.
- FSM, one outstanding transaction maximum:
  - IDLE: if FIFO non-empty -> ISSUE.
  - ISSUE: req_val=1. On req_val&&req_rdy, pop and clear the timeout counter -> WAIT. req_val stays high until the handshake; the operands must not change while high.
  - WAIT: rsp_rdy=1; the counter increments each cycle. On rsp_val, capture rsp_c into out_c -> DELIVER. Otherwise, if counter==TIMEOUT, set err, discard the transaction -> IDLE. rsp_val in the same cycle the counter reaches TIMEOUT takes priority (capture, no err).
  - DELIVER: out_val=1, out_c held. On out_rdy: sum += zero-extended out_c (mod 2^(n+4)), done_count += 1 (wraps 255->0) -> IDLE.
- rsp_rdy=0 outside WAIT. rsp_val outside WAIT is ignored.
- Minimum latency: pair pushed at edge k -> req_val high after edge k+1 -> with req_rdy=1, handshake at edge k+2 -> WAIT.
- Reset mid-operation clears everything, including buffered pairs and the captured product. This block and the multiplier share one reset, so no stale response survives.
- All outputs are registered or decoded from state; there is no combinational path from in_val, rsp_val or out_rdy to any ready or valid output.

Test Plan:
- Single op, multiplier model with 4-cycle latency, a=5, b=7, out_rdy=1 -> req handshake once with req_a=5, req_b=7; out_c=35 for exactly one cycle; sum=35; done_count=1; err=0.
- Burst of 6 pairs (1x1 ... 6x6) with DEPTH=4 -> in_rdy drops after 4 buffered; products delivered in order 1,4,9,16,25,36; sum=91; done_count=6.
- Backpressure: out_rdy=0 for 10 cycles after product 42 (6x7) -> out_val and out_c=42 held stable; rsp_rdy=0 and no new req_val during hold; release -> done_count increments once.
- Timeout: rsp_val stuck low after handshake -> err=1 exactly TIMEOUT+1 cycles after entering WAIT, FSM back to IDLE, next pair issues normally, err stays 1.
- Reset asserted in WAIT with 3 pairs buffered -> all outputs at reset values the same cycle; after release busy=0, in_rdy=1, no req_val.
- Wrap: 17 deliveries of 63 (with n=6) -> sum = 1071 mod 1024 = 47; done_count=17.

Source files
------------

// File: rtl/mul_valrdy_requester.sv
// Requester front end for the iterative multiplier: buffers operand pairs, issues them
// one at a time, forwards each product and keeps self-test sum/count/timeout status.
//
// state     | meaning
// S_IDLE    | nothing outstanding, waiting for a buffered pair
// S_ISSUE   | req_val high with the FIFO head until the multiplier accepts it
// S_WAIT    | rsp_rdy high, waiting for the product with a timeout count
// S_DELIVER | out_val high with the captured product until downstream accepts
module mul_valrdy_requester #(
    parameter int n       = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_val,
    output logic           in_rdy,
    input  logic [n-1:0]   in_a,
    input  logic [n-1:0]   in_b,
    output logic           req_val,
    input  logic           req_rdy,
    output logic [n-1:0]   req_a,
    output logic [n-1:0]   req_b,
    input  logic           rsp_val,
    output logic           rsp_rdy,
    input  logic [n-1:0]   rsp_c,
    output logic           out_val,
    input  logic           out_rdy,
    output logic [n-1:0]   out_c,
    output logic [n+3:0]   sum,
    output logic [7:0]     done_count,
    output logic           err,
    output logic           busy
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]     TMO_MAX  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [n-1:0]  r_mem_a [DEPTH];
    logic [n-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tmo;
    logic [n-1:0]  r_out_c;
    logic [n+3:0]  r_sum;
    logic [7:0]    r_done;
    logic          r_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rsp_fire;
    logic w_out_fire;
    logic w_tmo_hit;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = in_val && !w_full;
    assign w_pop      = (r_state == S_ISSUE) && req_rdy;
    assign w_rsp_fire = (r_state == S_WAIT) && rsp_val;
    assign w_out_fire = (r_state == S_DELIVER) && out_rdy;
    assign w_tmo_hit  = (r_tmo == TMO_MAX);

    // Operand FIFO; the head stays put while req_val is high because pops only happen on the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= in_a;
                r_mem_b[r_wr_ptr] <= in_b;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty) w_state_nxt = S_ISSUE;
            S_ISSUE:   if (req_rdy) w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A response arriving on the last allowed cycle still wins over the abort.
                if (rsp_val) begin
                    w_state_nxt = S_DELIVER;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DELIVER: if (out_rdy) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo   <= '0;
            r_out_c <= '0;
            r_sum   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_rsp_fire) begin
                r_out_c <= rsp_c;
            end
            if ((r_state == S_WAIT) && !rsp_val && w_tmo_hit) begin
                r_err <= 1'b1;
            end
            if (w_out_fire) begin
                r_sum  <= r_sum + (n+4)'(r_out_c);
                r_done <= r_done + 1'b1;
            end
        end
    end

    assign in_rdy     = !w_full;
    assign req_val    = (r_state == S_ISSUE);
    assign req_a      = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign req_b      = w_empty ? '0 : r_mem_b[r_rd_ptr];
    assign rsp_rdy    = (r_state == S_WAIT);
    assign out_val    = (r_state == S_DELIVER);
    assign out_c      = r_out_c;
    assign sum        = r_sum;
    assign done_count = r_done;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule
